// File: rtl/cb_filter_sched.sv
// ---------------------------------------------------------------------------
// cb_filter_sched
//
// Round-robin scheduler that shares one counting-bloom-filter update port
// pair among NumReq requesters. Each cycle at most one increment/decrement
// is granted and registered onto the filter's incr_*/decr_* ports. A live
// entry count keeps increments at or below Capacity and decrements at or
// above zero. Filter clears are sequenced once out of reset and on request.
//
// Handshake: a requester's operation is accepted in the cycle where
// req_valid_i[i] & req_ready_o[i] are both high. req_ready_o is a
// combinational function of req_valid_i/req_op_i, so a requester must not
// make its valid depend on its ready. An ineligible request keeps valid high
// and waits; the scan simply skips it.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   req_valid_i      per-requester request valid
//   req_ready_o      per-requester grant (one-hot or zero)
//   req_op_i         per-requester op: 0 = increment, 1 = decrement
//   req_data_i       per-requester item, requester i at [i*DataWidth +: DataWidth]
//   clear_req_i      single-cycle clear request pulse
//   clear_busy_o     clear cycle in progress (also exposes FSM state: 1 = CLEAR)
//   incr_valid_o     increment strobe to the filter, incr_data_o its item
//   decr_valid_o     decrement strobe to the filter, decr_data_o its item
//   filter_clear_o   clear strobe to the filter
//   usage_o          current live-entry count
// ---------------------------------------------------------------------------
module cb_filter_sched #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int Capacity  = 16,
  localparam int CntWidth = $clog2(Capacity + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0]             req_op_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic                          clear_req_i,
  output logic                          clear_busy_o,
  output logic                          incr_valid_o,
  output logic [DataWidth-1:0]          incr_data_o,
  output logic                          decr_valid_o,
  output logic [DataWidth-1:0]          decr_data_o,
  output logic                          filter_clear_o,
  output logic [CntWidth-1:0]           usage_o
);

  localparam int RrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e               state_q;
  logic [RrWidth-1:0]   rr_q;
  logic [CntWidth-1:0]  usage_q;
  logic                 incr_valid_q;
  logic [DataWidth-1:0] incr_data_q;
  logic                 decr_valid_q;
  logic [DataWidth-1:0] decr_data_q;

  logic [NumReq-1:0]    elig;
  logic                 gnt_found;
  logic [RrWidth-1:0]   gnt_idx;
  int                   scan_idx;
  logic                 gnt_op;
  logic [DataWidth-1:0] gnt_data;
  logic [RrWidth-1:0]   rr_d;
  logic [NumReq-1:0]    req_ready;

  // A full filter blocks only increments; an empty one blocks only decrements.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] &&
                (req_op_i[i] ? (usage_q != '0) : (usage_q < CntWidth'(Capacity)));
    end
  end

  // Scan from rr_q upward with wrap; first eligible requester wins.
  // A clear request in RUN suppresses every grant that cycle.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    if (state_q == RUN && !clear_req_i) begin
      for (int k = 0; k < NumReq; k++) begin
        scan_idx = (int'(rr_q) + k) % NumReq;
        if (!gnt_found && elig[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = RrWidth'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_op   = req_op_i[gnt_idx];
  assign gnt_data = req_data_i[int'(gnt_idx)*DataWidth +: DataWidth];
  assign rr_d     = (gnt_idx == RrWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CLEAR;
      rr_q         <= '0;
      usage_q      <= '0;
      incr_valid_q <= 1'b0;
      incr_data_q  <= '0;
      decr_valid_q <= 1'b0;
      decr_data_q  <= '0;
    end else begin
      incr_valid_q <= gnt_found && !gnt_op;
      decr_valid_q <= gnt_found && gnt_op;
      // Data registers only load on a strobe so they hold otherwise.
      if (gnt_found && !gnt_op) incr_data_q <= gnt_data;
      if (gnt_found && gnt_op)  decr_data_q <= gnt_data;
      if (gnt_found)            rr_q        <= rr_d;

      case (state_q)
        CLEAR: begin
          // clear_req_i is deliberately ignored here.
          state_q <= RUN;
          usage_q <= '0;
        end
        default: begin
          if (clear_req_i) state_q <= CLEAR;
          if (gnt_found) begin
            usage_q <= gnt_op ? usage_q - 1'b1 : usage_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready_o    = req_ready;
  assign clear_busy_o   = (state_q == CLEAR);
  assign filter_clear_o = (state_q == CLEAR);
  assign incr_valid_o   = incr_valid_q;
  assign incr_data_o    = incr_data_q;
  assign decr_valid_o   = decr_valid_q;
  assign decr_data_o    = decr_data_q;
  assign usage_o        = usage_q;

endmodule
